csr_regfile: RTL

Machine-mode CSR register file for the NPC core; the storage end of the trap interface. It holds the trap CSRs that the trap controller reads (mstatus, mepc, mcause, mtval, mtvec), and commits the trap controller's write-backs on ecall and mret. It also serves Zicsr instruction accesses from the execute stage and runs the mcycle/minstret counters. Reads are combinational; all state updates occur on the clock edge.

---
 rtl/csr_regfile_if.sv | 45 ++++
 rtl/csr_regfile.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/csr_regfile_if.sv
// Zicsr access, trap-controller write-back and trap CSR view for csr_regfile.
// The master side is execute stage plus trap controller; the slave side is the register file.
interface csr_regfile_if #(
  parameter int XLEN = 64
);
  logic [11:0]     csr_addr_i;
  logic [1:0]      csr_op_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;

  logic            trap_enter_i;
  logic            trap_mret_i;
  logic [XLEN-1:0] clint_mepc_i;
  logic            clint_mepc_valid_i;
  logic [XLEN-1:0] clint_mcause_i;
  logic            clint_mcause_valid_i;
  logic [XLEN-1:0] clint_mtval_i;
  logic            clint_mtval_valid_i;
  logic            inst_retire_i;

  logic [XLEN-1:0] mstatus_o;
  logic [XLEN-1:0] mepc_o;
  logic [XLEN-1:0] mcause_o;
  logic [XLEN-1:0] mtval_o;
  logic [XLEN-1:0] mtvec_o;

  modport master (
    output csr_addr_i, csr_op_i, csr_wdata_i,
    output trap_enter_i, trap_mret_i,
    output clint_mepc_i, clint_mepc_valid_i, clint_mcause_i, clint_mcause_valid_i,
    output clint_mtval_i, clint_mtval_valid_i, inst_retire_i,
    input  csr_rdata_o, csr_illegal_o,
    input  mstatus_o, mepc_o, mcause_o, mtval_o, mtvec_o
  );

  modport slave (
    input  csr_addr_i, csr_op_i, csr_wdata_i,
    input  trap_enter_i, trap_mret_i,
    input  clint_mepc_i, clint_mepc_valid_i, clint_mcause_i, clint_mcause_valid_i,
    input  clint_mtval_i, clint_mtval_valid_i, inst_retire_i,
    output csr_rdata_o, csr_illegal_o,
    output mstatus_o, mepc_o, mcause_o, mtval_o, mtvec_o
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational Zicsr reads, edge-committed writes, trap/mret
// write-back and mcycle/minstret counters. Reads are zero-latency; no backpressure.
module csr_regfile #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input logic          clk,
  input logic          rst,
  csr_regfile_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] MISA_VAL  = XLEN'(64'h8000_0000_0000_0100);
  localparam logic [XLEN-1:0] ALIGN4    = ~(XLEN'(3));
  localparam logic [XLEN-1:0] RETIRE_1  = XLEN'(1);

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            mapped;
  logic            read_only;
  logic            write_req;
  logic            illegal;
  logic            wr_en;

  // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie;
    mstatus_val[3]     = mie;
  end

  always_comb begin
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (bus.csr_addr_i)
      ADDR_MSTATUS:  old_val = mstatus_val;
      ADDR_MISA:     begin old_val = MISA_VAL; read_only = 1'b1; end
      ADDR_MTVEC:    old_val = mtvec;
      ADDR_MSCRATCH: old_val = mscratch;
      ADDR_MEPC:     old_val = mepc;
      ADDR_MCAUSE:   old_val = mcause;
      ADDR_MTVAL:    old_val = mtval;
      ADDR_MCYCLE:   old_val = mcycle;
      ADDR_MINSTRET: old_val = minstret;
      ADDR_MHARTID:  begin old_val = HART_ID; read_only = 1'b1; end
      default:       mapped = 1'b0;
    endcase
  end

  // Set/clear with a zero mask is a pure read, so it may target read-only CSRs.
  always_comb begin
    new_val   = old_val;
    write_req = 1'b0;
    case (bus.csr_op_i)
      OP_RW: begin new_val = bus.csr_wdata_i;            write_req = 1'b1; end
      OP_RS: begin new_val = old_val | bus.csr_wdata_i;  write_req = (bus.csr_wdata_i != '0); end
      OP_RC: begin new_val = old_val & ~bus.csr_wdata_i; write_req = (bus.csr_wdata_i != '0); end
      default: begin new_val = old_val; write_req = 1'b0; end
    endcase
  end

  assign illegal = ((bus.csr_op_i != 2'b00) && !mapped) || (write_req && read_only);
  assign wr_en   = write_req && mapped && !illegal;

  assign bus.csr_rdata_o   = illegal ? '0 : old_val;
  assign bus.csr_illegal_o = illegal;
  assign bus.mstatus_o     = mstatus_val;
  assign bus.mepc_o        = mepc;
  assign bus.mcause_o      = mcause;
  assign bus.mtval_o       = mtval;
  assign bus.mtvec_o       = mtvec;

  logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval, wr_mcycle, wr_minstret;

  always_comb begin
    wr_mstatus  = wr_en && (bus.csr_addr_i == ADDR_MSTATUS);
    wr_mtvec    = wr_en && (bus.csr_addr_i == ADDR_MTVEC);
    wr_mscratch = wr_en && (bus.csr_addr_i == ADDR_MSCRATCH);
    wr_mepc     = wr_en && (bus.csr_addr_i == ADDR_MEPC);
    wr_mcause   = wr_en && (bus.csr_addr_i == ADDR_MCAUSE);
    wr_mtval    = wr_en && (bus.csr_addr_i == ADDR_MTVAL);
    wr_mcycle   = wr_en && (bus.csr_addr_i == ADDR_MCYCLE);
    wr_minstret = wr_en && (bus.csr_addr_i == ADDR_MINSTRET);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= wr_mcycle ? new_val : mcycle + RETIRE_1;
      minstret <= wr_minstret ? new_val
                              : (bus.inst_retire_i ? minstret + RETIRE_1 : minstret);

      // Trap entry wins over mret; either one drops a same-cycle Zicsr mstatus write.
      if (bus.trap_enter_i) begin
        mpie <= mie;
        mie  <= 1'b0;
      end else if (bus.trap_mret_i) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mie  <= new_val[3];
        mpie <= new_val[7];
      end

      if (bus.trap_enter_i && bus.clint_mepc_valid_i) mepc <= bus.clint_mepc_i & ALIGN4;
      else if (wr_mepc)                                mepc <= new_val & ALIGN4;

      if (bus.trap_enter_i && bus.clint_mcause_valid_i) mcause <= bus.clint_mcause_i;
      else if (wr_mcause)                                mcause <= new_val;

      if (bus.trap_enter_i && bus.clint_mtval_valid_i) mtval <= bus.clint_mtval_i;
      else if (wr_mtval)                                mtval <= new_val;

      if (wr_mtvec)    mtvec    <= new_val & ALIGN4;
      if (wr_mscratch) mscratch <= new_val;
    end
  end

endmodule
